// File: rtl/simple_log_rd_arbiter.sv
// simple_log_rd_arbiter: round-robin sharing of one in-order log memory read port among several readers.
// An owner FIFO remembers who issued each read so in-order responses can be steered back.
module simple_log_rd_arbiter #(
  parameter int NUM_CLIENTS        = 2,
  parameter int ADDR_W             = 8,
  parameter int RESP_DATA_STRUCT_W = 32,
  parameter int MAX_OUTSTANDING    = 4,
  localparam int IW = NUM_CLIENTS > 1 ? $clog2(NUM_CLIENTS) : 1,
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CLIENTS-1:0]          client_rd_req_val,
  input  logic [NUM_CLIENTS*ADDR_W-1:0]   client_rd_req_addr,
  output logic [NUM_CLIENTS-1:0]          client_rd_req_rdy,
  output logic [NUM_CLIENTS-1:0]          client_rd_resp_val,
  output logic [RESP_DATA_STRUCT_W-1:0]   client_rd_resp_data,
  output logic                            log_rd_req_val,
  output logic [ADDR_W-1:0]               log_rd_req_addr,
  input  logic                            log_rd_resp_val,
  input  logic [RESP_DATA_STRUCT_W-1:0]   log_rd_resp_data,
  output logic [CW-1:0]                   outstanding_cnt,
  output logic                            err_spurious_resp
);
  logic [IW-1:0]                 rr_q, gnt;
  logic [PW-1:0]                 wr_q, rd_q;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [IW-1:0]                 owner_q [MAX_OUTSTANDING];
  logic [NUM_CLIENTS-1:0]        resp_val_q;
  logic [RESP_DATA_STRUCT_W-1:0] resp_data_q;
  logic                          err_q, found, issue, pop;
  int                            idx;
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      idx = (int'(rr_q) + k) % NUM_CLIENTS;
      if (!found && client_rd_req_val[idx]) begin
        found = 1'b1;
        gnt   = IW'(idx);
      end
    end
  end
  // rst_n gates the combinational issue path so every output is quiet while in reset
  assign issue = rst_n & (cnt_q < CW'(MAX_OUTSTANDING)) & found;
  assign pop   = log_rd_resp_val & (cnt_q != '0);
  assign cnt_d = cnt_q + CW'(issue) - CW'(pop);
  assign client_rd_req_rdy   = issue ? NUM_CLIENTS'(1) << gnt : '0;
  assign log_rd_req_val      = issue;
  assign log_rd_req_addr     = issue ? client_rd_req_addr[gnt*ADDR_W +: ADDR_W] : '0;
  assign client_rd_resp_val  = resp_val_q;
  assign client_rd_resp_data = resp_data_q;
  assign outstanding_cnt     = cnt_q;
  assign err_spurious_resp   = err_q;
  always_ff @(posedge clk) if (issue) owner_q[wr_q] <= gnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      resp_val_q  <= '0;
      resp_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      resp_val_q <= pop ? NUM_CLIENTS'(1) << owner_q[rd_q] : '0;
      cnt_q      <= cnt_d;
      if (pop) begin
        resp_data_q <= log_rd_resp_data;
        rd_q        <= rd_q == PW'(MAX_OUTSTANDING - 1) ? '0 : rd_q + 1'b1;
      end
      if (log_rd_resp_val && cnt_q == '0) err_q <= 1'b1;
      if (issue) begin
        wr_q <= wr_q == PW'(MAX_OUTSTANDING - 1) ? '0 : wr_q + 1'b1;
        rr_q <= gnt == IW'(NUM_CLIENTS - 1) ? '0 : gnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_simple_log_rd_arbiter.sv
// tb_simple_log_rd_arbiter: directed scenarios with an owner/response scoreboard for simple_log_rd_arbiter.
module tb_simple_log_rd_arbiter;
  localparam int N = 2, AW = 8, DW = 32, MO = 4;
  logic            clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]    val = '0;
  logic [N*AW-1:0] addr = {8'h21, 8'h10};
  logic            resp_v = 1'b0;
  logic [DW-1:0]   resp_d = '0;
  logic [N-1:0]    rdy, cval;
  logic [DW-1:0]   cdata;
  logic            lv, err;
  logic [AW-1:0]   la;
  logic [2:0]      cnt;
  int              passed = 0, total = 0, rr_m = 0;
  logic [N-1:0]    own_q[$];
  logic [N-1:0]    exp_o, exp_r;
  logic [AW-1:0]   exp_a;

  simple_log_rd_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .RESP_DATA_STRUCT_W(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst_n(rst_n), .client_rd_req_val(val), .client_rd_req_addr(addr),
    .client_rd_req_rdy(rdy), .client_rd_resp_val(cval), .client_rd_resp_data(cdata),
    .log_rd_req_val(lv), .log_rd_req_addr(la), .log_rd_resp_val(resp_v), .log_rd_resp_data(resp_d),
    .outstanding_cnt(cnt), .err_spurious_resp(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; val = 2'b11; #2;
    total++; if (rdy !== 2'b00) $display("FAIL reset_rdy: got %b want 00", rdy); else passed++;
    total++; if (lv !== 1'b0) $display("FAIL reset_lv: got %b want 0", lv); else passed++;
    total++; if (la !== 8'h00) $display("FAIL reset_la: got %h want 00", la); else passed++;
    total++; if (cnt !== 3'd0) $display("FAIL reset_cnt: got %0d want 0", cnt); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
    total++; if (cval !== 2'b00) $display("FAIL reset_cval: got %b want 00", cval); else passed++;
    total++; if (cdata !== 32'h0) $display("FAIL reset_cdata: got %h want 0", cdata); else passed++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; val = '0; rr_m = 0;
  endtask

  task automatic test_single;
    val = 2'b01;
    @(negedge clk);
    total++; if (rdy !== 2'b01) $display("FAIL single_rdy: got %b want 01", rdy); else passed++;
    total++; if (lv !== 1'b1) $display("FAIL single_lv: got %b want 1", lv); else passed++;
    total++; if (la !== 8'h10) $display("FAIL single_la: got %h want 10", la); else passed++;
    own_q.push_back(2'b01); rr_m = 1;
    tick; val = '0;
    total++; if (cnt !== 3'd1) $display("FAIL single_cnt1: got %0d want 1", cnt); else passed++;
    tick; tick;
    resp_v = 1'b1; resp_d = 32'hD0D0_0000; exp_o = own_q.pop_front();
    tick; resp_v = 1'b0;
    total++; if (cval !== exp_o) $display("FAIL single_cval: got %b want %b", cval, exp_o); else passed++;
    total++; if (cdata !== 32'hD0D0_0000) $display("FAIL single_cdata: got %h want d0d00000", cdata); else passed++;
    total++; if (cnt !== 3'd0) $display("FAIL single_cnt0: got %0d want 0", cnt); else passed++;
    tick;
    total++; if (cval !== 2'b00) $display("FAIL single_cval_idle: got %b want 00", cval); else passed++;
    total++; if (cdata !== 32'hD0D0_0000) $display("FAIL single_cdata_hold: got %h want d0d00000", cdata); else passed++;
  endtask

  task automatic test_alternate;
    val = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_r = 2'b01 << rr_m; exp_a = rr_m == 1 ? 8'h21 : 8'h10;
      total++; if (rdy !== exp_r) $display("FAIL alt_rdy%0d: got %b want %b", i, rdy, exp_r); else passed++;
      total++; if (la !== exp_a) $display("FAIL alt_la%0d: got %h want %h", i, la, exp_a); else passed++;
      own_q.push_back(exp_r); rr_m = 1 - rr_m;
      tick;
      total++; if (cnt !== 3'(i + 1)) $display("FAIL alt_cnt%0d: got %0d want %0d", i, cnt, i + 1); else passed++;
    end
    @(negedge clk);
    total++; if (rdy !== 2'b00) $display("FAIL alt_full_rdy: got %b want 00", rdy); else passed++;
    tick; val = '0;
    for (int i = 0; i < 4; i++) begin
      resp_v = 1'b1; resp_d = 32'hA000 + i; exp_o = own_q.pop_front();
      tick;
      total++; if (cval !== exp_o) $display("FAIL alt_cval%0d: got %b want %b", i, cval, exp_o); else passed++;
      total++; if (cdata !== 32'hA000 + i) $display("FAIL alt_cdata%0d: got %h want %h", i, cdata, 32'hA000 + i); else passed++;
    end
    resp_v = 1'b0;
    tick;
    total++; if (cnt !== 3'd0) $display("FAIL alt_drain_cnt: got %0d want 0", cnt); else passed++;
    total++; if (cval !== 2'b00) $display("FAIL alt_drain_cval: got %b want 00", cval); else passed++;
  endtask

  task automatic test_full;
    val = 2'b10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (rdy !== 2'b10) $display("FAIL full_b2b_rdy%0d: got %b want 10", i, rdy); else passed++;
      own_q.push_back(2'b10);
      tick;
    end
    rr_m = 0;
    total++; if (cnt !== 3'd4) $display("FAIL full_cnt4: got %0d want 4", cnt); else passed++;
    resp_v = 1'b1; resp_d = 32'hB000_0000; exp_o = own_q.pop_front();
    @(negedge clk);
    total++; if (rdy !== 2'b00) $display("FAIL full_rdy_with_resp: got %b want 00", rdy); else passed++;
    total++; if (lv !== 1'b0) $display("FAIL full_lv_with_resp: got %b want 0", lv); else passed++;
    tick; resp_v = 1'b0;
    total++; if (cval !== exp_o) $display("FAIL full_cval: got %b want %b", cval, exp_o); else passed++;
    total++; if (cnt !== 3'd3) $display("FAIL full_cnt3: got %0d want 3", cnt); else passed++;
    @(negedge clk);
    total++; if (rdy !== 2'b10) $display("FAIL full_resume_rdy: got %b want 10", rdy); else passed++;
    own_q.push_back(2'b10);
    tick;
    total++; if (cnt !== 3'd4) $display("FAIL full_cnt_refill: got %0d want 4", cnt); else passed++;
    @(negedge clk);
    total++; if (rdy !== 2'b00) $display("FAIL full_one_more_only: got %b want 00", rdy); else passed++;
    tick; val = '0;
    for (int i = 0; i < 4; i++) begin
      resp_v = 1'b1; resp_d = 32'hB000_0001 + i; exp_o = own_q.pop_front();
      tick;
      total++; if (cval !== exp_o) $display("FAIL full_drain_cval%0d: got %b want %b", i, cval, exp_o); else passed++;
      total++; if (cdata !== 32'hB000_0001 + i) $display("FAIL full_drain_cdata%0d: got %h want %h", i, cdata, 32'hB000_0001 + i); else passed++;
    end
    resp_v = 1'b0;
    tick;
    total++; if (cnt !== 3'd0) $display("FAIL full_drain_cnt: got %0d want 0", cnt); else passed++;
  endtask

  task automatic test_same_cycle;
    val = 2'b01;
    @(negedge clk);
    total++; if (rdy !== 2'b01) $display("FAIL same_rdy_a: got %b want 01", rdy); else passed++;
    own_q.push_back(2'b01);
    tick; val = 2'b10;
    @(negedge clk);
    total++; if (rdy !== 2'b10) $display("FAIL same_rdy_b: got %b want 10", rdy); else passed++;
    own_q.push_back(2'b10);
    tick;
    total++; if (cnt !== 3'd2) $display("FAIL same_cnt_pre: got %0d want 2", cnt); else passed++;
    val = 2'b01; resp_v = 1'b1; resp_d = 32'hC000_0000; exp_o = own_q.pop_front();
    @(negedge clk);
    total++; if (rdy !== 2'b01) $display("FAIL same_rdy_c: got %b want 01", rdy); else passed++;
    own_q.push_back(2'b01); rr_m = 1;
    tick; val = '0; resp_v = 1'b0;
    total++; if (cnt !== 3'd2) $display("FAIL same_cnt_post: got %0d want 2", cnt); else passed++;
    total++; if (cval !== exp_o) $display("FAIL same_cval: got %b want %b", cval, exp_o); else passed++;
    total++; if (cdata !== 32'hC000_0000) $display("FAIL same_cdata: got %h want c0000000", cdata); else passed++;
    for (int i = 0; i < 2; i++) begin
      resp_v = 1'b1; resp_d = 32'hC000_0001 + i; exp_o = own_q.pop_front();
      tick;
      total++; if (cval !== exp_o) $display("FAIL same_drain_cval%0d: got %b want %b", i, cval, exp_o); else passed++;
    end
    resp_v = 1'b0;
    tick;
    total++; if (cnt !== 3'd0) $display("FAIL same_drain_cnt: got %0d want 0", cnt); else passed++;
  endtask

  task automatic test_spurious;
    resp_v = 1'b1; resp_d = 32'hE000_0000;
    tick; resp_v = 1'b0;
    total++; if (cval !== 2'b00) $display("FAIL spur_cval: got %b want 00", cval); else passed++;
    total++; if (err !== 1'b1) $display("FAIL spur_err: got %b want 1", err); else passed++;
    total++; if (cnt !== 3'd0) $display("FAIL spur_cnt: got %0d want 0", cnt); else passed++;
    repeat (3) tick;
    total++; if (err !== 1'b1) $display("FAIL spur_err_sticky: got %b want 1", err); else passed++;
  endtask

  task automatic test_reset_mid;
    val = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_r = 2'b01 << rr_m;
      total++; if (rdy !== exp_r) $display("FAIL mid_rdy%0d: got %b want %b", i, rdy, exp_r); else passed++;
      own_q.push_back(exp_r); rr_m = 1 - rr_m;
      tick;
    end
    total++; if (cnt !== 3'd3) $display("FAIL mid_cnt3: got %0d want 3", cnt); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (rdy !== 2'b00) $display("FAIL mid_rst_rdy: got %b want 00", rdy); else passed++;
    total++; if (lv !== 1'b0) $display("FAIL mid_rst_lv: got %b want 0", lv); else passed++;
    total++; if (cnt !== 3'd0) $display("FAIL mid_rst_cnt: got %0d want 0", cnt); else passed++;
    total++; if (err !== 1'b0) $display("FAIL mid_rst_err: got %b want 0", err); else passed++;
    total++; if (cdata !== 32'h0) $display("FAIL mid_rst_cdata: got %h want 0", cdata); else passed++;
    own_q.delete(); rr_m = 0;
    tick;
    rst_n = 1'b1; val = 2'b10;
    @(negedge clk);
    total++; if (rdy !== 2'b10) $display("FAIL mid_post_rdy: got %b want 10", rdy); else passed++;
    total++; if (la !== 8'h21) $display("FAIL mid_post_la: got %h want 21", la); else passed++;
    tick; val = '0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_alternate;
    test_full;
    test_same_cycle;
    test_spurious;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
